// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory/cache port between an instruction-fetch requester (i_*)
//   and a load/store requester (d_*). One access is in flight at a time. The
//   arbiter waits out m_busy, returns read data with a one-cycle done pulse,
//   and raises a sticky err if the memory stays busy past TIMEOUT cycles.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : simultaneous requests go to the port that did not win last
//     undefined : fixed priority, data requester wins over fetch
//
// Parameters
//   NBITS    address/data width
//   TIMEOUT  max WAIT cycles with m_busy high before abort (>= 1)
//
// Ports
//   clock, reset (async, active-low)
//   i_req/i_addr -> i_gnt/i_done/i_rdata            fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_done/d_rdata load/store requester
//   m_addr/m_wdata/m_re/m_we -> memory, m_busy/m_rdata <- memory
//   err  sticky timeout flag, cleared only by reset
module mem_port_arbiter #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_req,
  input  logic [NBITS-1:0] i_addr,
  output logic             i_gnt,
  output logic             i_done,
  output logic [NBITS-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [NBITS-1:0] d_addr,
  input  logic [NBITS-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_done,
  output logic [NBITS-1:0] d_rdata,
  output logic [NBITS-1:0] m_addr,
  output logic [NBITS-1:0] m_wdata,
  output logic             m_re,
  output logic             m_we,
  input  logic             m_busy,
  input  logic [NBITS-1:0] m_rdata,
  output logic             err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, last_q, win;
  logic             grant_any;
  logic             rd_ok;
  logic             rd_to;
  logic             we_q;
  logic [NBITS-1:0] addr_q, wdata_q;
  logic [NBITS-1:0] i_rdata_q, d_rdata_q;
  logic [CW-1:0]    cnt_q;
  logic             err_q;
  owner_t           both_win;

`ifdef ARB_ROUND_ROBIN_EN
  assign both_win = (last_q == OWN_I) ? OWN_D : OWN_I;
`else
  // last is still tracked in fixed-priority mode but never consulted.
  logic last_unused;
  assign last_unused = last_q;
  assign both_win    = OWN_D;
`endif

  always_comb begin
    state_d   = state_q;
    win       = OWN_I;
    grant_any = 1'b0;
    rd_ok     = 1'b0;
    rd_to     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant_any = 1'b1;
          state_d   = ISSUE;
          if (i_req && d_req) win = both_win;
          else                win = d_req ? OWN_D : OWN_I;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // busy-low completion takes precedence over a coincident timeout
        if (!m_busy) begin
          rd_ok   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_MAX) begin
          rd_to   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_D;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if (grant_any) begin
        owner_q <= win;
        if (win == OWN_D) begin
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
          we_q    <= d_we;
        end else begin
          addr_q  <= i_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
        end
      end

      if (state_q == ISSUE) begin
        cnt_q <= '0;
      end else if (state_q == WAIT && m_busy && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (rd_ok && !we_q) begin
        if (owner_q == OWN_D) d_rdata_q <= m_rdata;
        else                  i_rdata_q <= m_rdata;
      end

      if (rd_to) begin
        err_q <= 1'b1;
        if (!we_q) begin
          if (owner_q == OWN_D) d_rdata_q <= '0;
          else                  i_rdata_q <= '0;
        end
      end

      if (state_q == DONE) last_q <= owner_q;
    end
  end

  // Strobes, grants and done decode straight from registered state so they
  // drop the moment reset asserts.
  assign m_re    = (state_q == ISSUE) && !we_q;
  assign m_we    = (state_q == ISSUE) &&  we_q;
  assign i_gnt   = (state_q != IDLE) && (owner_q == OWN_I);
  assign d_gnt   = (state_q != IDLE) && (owner_q == OWN_D);
  assign i_done  = (state_q == DONE) && (owner_q == OWN_I);
  assign d_done  = (state_q == DONE) && (owner_q == OWN_D);
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       i_req, d_req, d_we, m_busy;
  logic [7:0] i_addr, d_addr, d_wdata, m_rdata;
  logic       i_gnt, i_done, d_gnt, d_done, m_re, m_we, err;
  logic [7:0] i_rdata, d_rdata, m_addr, m_wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.NBITS(8), .TIMEOUT(15)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_done  (i_done),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_done  (d_done),
    .d_rdata (d_rdata),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_re    (m_re),
    .m_we    (m_we),
    .m_busy  (m_busy),
    .m_rdata (m_rdata),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Advance until a done pulse is seen (bounded); n = cycles advanced.
  task automatic wait_done(input int limit, output int n, output logic di, output logic dd,
                           output logic gi, output logic gd);
    n = 0; di = 1'b0; dd = 1'b0; gi = 1'b0; gd = 1'b0;
    while (n < limit && !di && !dd) begin
      tick();
      n++;
      gi = gi | i_gnt;
      gd = gd | d_gnt;
      di = i_done;
      dd = d_done;
    end
    if (!di && !dd) chk("done_wait_expired", 32'd0, 32'd1);
  endtask

  int   n;
  logic di, dd, gi, gd, gi_all, first_d, second_d, saw_done;

  initial begin
    reset = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; m_busy = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    repeat (2) @(negedge clock);

    // reset state
    chk("rst_strobes", {m_re, m_we, i_gnt, d_gnt, i_done, d_done, err}, 32'd0);
    chk("rst_rdata", {i_rdata, d_rdata}, 32'd0);
    chk("rst_mbus", {m_addr, m_wdata}, 32'd0);
    reset = 1'b1;
    tick();

    // single fetch
    i_req = 1; i_addr = 8'h10; m_rdata = 8'hA5; m_busy = 0;
    tick();
    chk("f_c1_mre", {m_re, m_we}, 32'b10);
    chk("f_c1_gnt", {i_gnt, d_gnt}, 32'b10);
    chk("f_c1_addr", m_addr, 32'h10);
    tick();
    chk("f_c2_mre", m_re, 32'd0);
    chk("f_c2_done", {i_done, d_gnt}, 32'd0);
    tick();
    chk("f_c3_done", {i_done, d_done, d_gnt}, 32'b100);
    chk("f_c3_rdata", i_rdata, 32'hA5);
    i_req = 0;
    tick();
    chk("f_idle", {i_gnt, i_done}, 32'd0);

    // store with 4 busy WAIT cycles
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h3C; m_busy = 1; m_rdata = 8'h77;
    tick();
    chk("s_c1_mwe", {m_we, m_re}, 32'b10);
    chk("s_c1_bus", {m_addr, m_wdata}, 32'h203C);
    chk("s_c1_gnt", {d_gnt, i_gnt}, 32'b10);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("s_wait_nodone", {d_done, m_we}, 32'd0);
      if (c == 6) m_busy = 0;
    end
    tick();
    chk("s_c7_done", d_done, 32'd1);
    chk("s_c7_bus", {m_addr, m_wdata}, 32'h203C);
    chk("s_rdata_kept", d_rdata, 32'h00);
    d_req = 0; d_we = 0;
    tick();

    // contention: both held for two transactions
    i_req = 1; i_addr = 8'h30; d_req = 1; d_addr = 8'h40; m_rdata = 8'h5A; m_busy = 0;
    wait_done(10, n, di, dd, gi, gd);
    chk("c1_lat", n, 32'd3);
    first_d = dd; gi_all = gi;
    wait_done(10, n, di, dd, gi, gd);
    chk("c2_lat", n, 32'd4);
    second_d = dd; gi_all = gi_all | gi;
    i_req = 0; d_req = 0;
`ifdef ARB_ROUND_ROBIN_EN
    chk("c_order", {first_d, second_d}, 32'b01);
    chk("c_i_rdata", i_rdata, 32'h5A);
`else
    chk("c_order", {first_d, second_d}, 32'b11);
    chk("c_no_igrant", gi_all, 32'd0);
`endif
    chk("c_d_rdata", d_rdata, 32'h5A);
    tick();

    // timeout on a stuck load
    d_req = 1; d_we = 0; d_addr = 8'h50; m_busy = 1; m_rdata = 8'hFF;
    tick();
    chk("t_c1_mre", m_re, 32'd1);
    chk("t_c1_err", err, 32'd0);
    wait_done(40, n, di, dd, gi, gd);
    chk("t_lat", n, 32'd17);
    chk("t_who", {di, dd}, 32'b01);
    chk("t_rdata", d_rdata, 32'h00);
    chk("t_err", err, 32'd1);
    d_req = 0; m_busy = 0;
    tick();
    i_req = 1; i_addr = 8'h60; m_rdata = 8'hC3;
    wait_done(10, n, di, dd, gi, gd);
    i_req = 0;
    chk("t_f_lat", n, 32'd3);
    chk("t_f_rdata", i_rdata, 32'hC3);
    chk("t_err_sticky", err, 32'd1);
    tick();

    // reset mid-WAIT
    d_req = 1; d_we = 0; d_addr = 8'h70; m_busy = 1;
    tick();
    tick();
    chk("r_pre_gnt", {d_gnt, err}, 32'b11);
    reset = 1'b0;
    #1;
    chk("r_async", {m_re, d_gnt, err, d_done}, 32'd0);
    d_req = 0; m_busy = 0;
    saw_done = 1'b0;
    repeat (3) begin
      tick();
      saw_done = saw_done | d_done | i_done;
    end
    chk("r_no_done", saw_done, 32'd0);
    reset = 1'b1;
    tick();
    chk("r_idle", {i_gnt, d_gnt, m_re, m_we}, 32'd0);
    chk("r_rdata", {i_rdata, d_rdata}, 32'd0);
    i_req = 1; i_addr = 8'h80; m_rdata = 8'hE7;
    wait_done(10, n, di, dd, gi, gd);
    i_req = 0;
    chk("r_f_lat", n, 32'd3);
    chk("r_f_rdata", i_rdata, 32'hE7);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory/cache port between the controller's instruction-fetch requester and its load/store requester. Sits between the controller and the memory/cache. It arbitrates, issues one access at a time, and waits out `m_busy`. It returns read data and a completion pulse to the winning requester, and flags a stuck memory with a timeout.

## Interface
Parameters:
- `NBITS`, 8, address and data width.
- `TIMEOUT`, 15, maximum WAIT cycles with `m_busy` high before the access is aborted; must be ≥1.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held high with `i_addr` stable until `i_done`.
- `i_addr`  in  NBITS  fetch address.
- `i_gnt`  out  1  fetch owns the port (ISSUE/WAIT/DONE with owner=I).
- `i_done`  out  1  one-cycle fetch completion pulse.
- `i_rdata`  out  NBITS  last fetched data; registered; held between completions.
- `d_req`  in  1  load/store request; held with `d_we`/`d_addr`/`d_wdata` stable until `d_done`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  NBITS  data address.
- `d_wdata`  in  NBITS  store data.
- `d_gnt`  out  1  data requester owns the port.
- `d_done`  out  1  one-cycle data completion pulse.
- `d_rdata`  out  NBITS  last load data; registered; unchanged by stores.
- `m_addr`  out  NBITS  memory address (latched copy).
- `m_wdata`  out  NBITS  memory write data (latched copy).
- `m_re`  out  1  memory read strobe (`MemRead`).
- `m_we`  out  1  memory write strobe (`MemWrite`).
- `m_busy`  in  1  memory still working; data not ready.
- `m_rdata`  in  NBITS  memory read data, valid in a WAIT cycle with `m_busy` low.
- `err`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. A registered `owner` (I/D) is kept, plus `last` (the most recent owner, used by round-robin).
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner, latch `owner`, address, wdata and we, then go to ISSUE.
  - Only one request: that requester wins.
  - Both requesting: the winner is set per the Configuration section.
- ISSUE:
  - Drive `m_re` (load/fetch) or `m_we` (store) for exactly one cycle.
  - Clear the wait counter.
  - Go to WAIT.
- WAIT:
  - `m_busy` low: capture `m_rdata` into the owner's rdata register (loads/fetches only), then go to DONE.
  - `m_busy` high: increment the counter.
  - Counter reaches `TIMEOUT` with `m_busy` still high: set `err`, load 0 into the owner's rdata (reads only), then go to DONE.
- DONE:
  - Pulse the owner's `done` for one cycle.
  - Update `last` to `owner`.
  - Go to IDLE.
- A requester that still has `req` high in the cycle after `done` is treated as making a new request.
- `m_addr`/`m_wdata` hold their latched values from ISSUE through DONE.
- `x_gnt` is high from ISSUE through DONE for the owner only.
- Counter width is `$clog2(TIMEOUT+1)`. The counter saturates and never wraps.
- `err` is cleared only by reset. Once set, it does not block later transactions.
- Reset asserted mid-transaction:
  - All state returns to IDLE immediately (asynchronous).
  - `m_re`/`m_we`/`gnt`/`done`/`err` drop to 0 immediately.
  - The in-flight access is abandoned with no `done` pulse.
- Reset values: all outputs 0, `rdata` registers 0, `owner`=I, `last`=D.

## Timing
- The request is sampled at edge 0.
- ISSUE occupies cycle 1.
- WAIT first occupies cycle 2.
- With `m_busy` low in cycle 2, DONE (`done`=1, `rdata` valid) falls in cycle 3.
- Minimum latency is 3 cycles from request sample to `done`, and 4 cycles per transaction including IDLE.
- Each extra busy cycle adds one cycle of latency.
- Timeout path: `done` occurs `TIMEOUT`+2 cycles after ISSUE.
- No arbitration takes place in DONE, so back-to-back grants are separated by one IDLE cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: on simultaneous `i_req`/`d_req` in IDLE, the grant goes to the port that is not `last`. After reset, fetch wins first.
  - Undefined: fixed priority; data always wins over fetch. `last` is still maintained but unused.

## Test plan
- Single fetch: `i_req`=1, `i_addr`=8'h10; memory returns 8'hA5 with `m_busy`=0. Required: `m_re` high exactly in cycle 1, `i_done` in cycle 3, `i_rdata`=8'hA5, `d_gnt` never high.
- Store with wait: `d_req`=1, `d_we`=1, `d_addr`=8'h20, `d_wdata`=8'h3C, `m_busy` high for 4 WAIT cycles. Required: `m_we`=1 for one cycle with `m_addr`=8'h20/`m_wdata`=8'h3C; `d_done` in cycle 7; `d_rdata` unchanged.
- Contention: `i_req` and `d_req` rise together and both are held for two transactions.
  - With `ARB_ROUND_ROBIN_EN`: order is I, then D.
  - Without it: order is D, then D again while `d_req` is held; `i_gnt` stays 0.
- Timeout: load with `m_busy` stuck high, `TIMEOUT`=15. Required: `d_done` 17 cycles after ISSUE, `d_rdata`=0, `err`=1; `err` persists through a following normal fetch that completes correctly.
- Reset mid-WAIT: `reset` driven low during WAIT with `m_busy` high. Required: `m_re`, `d_gnt` and `err` go to 0 without a clock edge, there is no `done` pulse, and the FSM is in IDLE after reset releases.
